// File: rtl/alu_arb_ctrl.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One command in flight: IDLE grants, EXEC drives the ALU and captures, RESP holds the result.
module alu_arb_ctrl #(
  parameter int unsigned DW = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [2:0]    req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [2:0]    req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_rslt,
  input  logic          alu_taken,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [DW-1:0] rsp_rslt,
  output logic          rsp_taken,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            last_q, last_d;
  logic [2:0]      op_q, op_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   rslt_q, rslt_d;
  logic            taken_q, taken_d;
  logic            win;

  // A lone requester always wins; on a tie the one not granted last wins.
  always_comb begin
    win = 1'b0;
    case (req_valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rslt_d  = rslt_q;
    taken_d = taken_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          gnt_d   = win;
          op_d    = win ? req1_op : req0_op;
          a_d     = win ? req1_a  : req0_a;
          b_d     = win ? req1_b  : req0_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rslt_d  = alu_rslt;
        taken_d = alu_taken;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[gnt_q]) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rslt_q  <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rslt_q  <= rslt_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    alu_op    = '0;
    alu_a     = '0;
    alu_b     = '0;
    if (state_q == IDLE && (|req_valid)) req_ready = win ? 2'b10 : 2'b01;
    if (state_q == RESP)                 rsp_valid = gnt_q ? 2'b10 : 2'b01;
    if (state_q == EXEC) begin
      alu_op = op_q;
      alu_a  = a_q;
      alu_b  = b_q;
    end
  end

  assign rsp_rslt  = rslt_q;
  assign rsp_taken = taken_q;
  assign busy      = (state_q != IDLE);

endmodule
